iis_transmit: RTL
=================

# iis_transmit

I2S-style serial audio transmitter and the transmit-side counterpart of the IIS receive path. It pops 16-bit samples from a read FIFO and alternates left and right channel slots. It drives the word-select (WS) and serial data (SD) lines MSB-first, framed so the IIS receiver on the same `clk` captures every sample unchanged. A run ends after `data_depth` samples, or after the frame in progress when `tx_en` is dropped.

## Interface
- `data_depth`, default 1024: samples per run. Must be even, so every run ends on a right slot.
- `SLOT_CYCLES`, default 32: `clk` cycles per channel slot. Minimum 17.
- `clk`  in  1: bit clock. Every register updates on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `tx_en`  in  1: run enable. Sampled in IDLE and at frame boundaries.
- `fifo_empty`  in  1: source FIFO is empty.
- `fifo_rdata`  in  16: FIFO read data, valid the cycle after `fifo_rden`.
- `fifo_rden`  out  1: combinational pop request, one cycle per sample.
- `WS`  out  1: word select, registered. 1 = left slot, 0 = right slot.
- `SD`  out  1: serial data, registered, MSB first.
- `tx_busy`  out  1: high in LEFT or RIGHT.
- `tx_num`  out  32: slots transmitted in the current run.
- `tx_finish`  out  1: one-cycle pulse when `tx_num` reaches `data_depth`.
- `tx_underrun`  out  1: sticky. Set when a slot finds the FIFO empty; cleared while `tx_en` = 0.

## Operation
- Reset values: all outputs 0, state IDLE, slot counter `c` = 0, shift register 0.
- States:
  - IDLE: WS = 0, SD = 0.
  - LEFT: WS = 1.
  - RIGHT: WS = 0.
- Slot counter `c` runs 0..SLOT_CYCLES-1 in LEFT and RIGHT. `c` = 0 is the first cycle WS shows its new level.
- Start: in IDLE with `tx_en` = 1 and `fifo_empty` = 0:
  - assert `fifo_rden` for that cycle;
  - at the next edge enter LEFT with `c` = 0 and WS <= 1.
- Per slot:
  - During `c` = 0, the prefetched word is on `fifo_rdata`.
  - At the edge ending `c` = 0, SD <= word[15] and the shift register loads word[14:0].
  - At each of the next 15 edges, SD takes the next bit. SD carries bits 15..0 during `c` = 1..16.
  - SD = 0 for `c` = 17..SLOT_CYCLES-1.
- Prefetch: during `c` = SLOT_CYCLES-1 of each slot that continues, assert `fifo_rden` if `fifo_empty` = 0.
- Underrun: if `fifo_empty` = 1 at the prefetch cycle:
  - no pop is issued;
  - the next slot transmits 16'h0000;
  - `tx_underrun` <= 1.
- `tx_num` increments at the edge ending `c` = 0 of every slot, including zero-filled slots.
- LEFT, `c` = SLOT_CYCLES-1: go to RIGHT, WS <= 0, `c` <= 0.
- RIGHT, `c` = SLOT_CYCLES-1:
  - If `tx_en` = 0 or `tx_num` == `data_depth`: go to IDLE with no pop.
  - Otherwise: go to LEFT, WS <= 1, `c` <= 0.
- On the IDLE transition caused by `tx_num` == `data_depth`:
  - `tx_finish` pulses for one cycle;
  - `tx_num` <= 0.
- `tx_num` is also forced to 0 while in IDLE with `tx_en` = 0.
- `tx_en` dropping mid-frame: the current left and right slots complete normally. No partial slot is ever emitted.
- `tx_en` high with FIFO empty in IDLE: stay in IDLE. `tx_underrun` is not set.
- `rst` mid-slot: immediate return to reset values. WS and SD go low asynchronously.

## Timing
- WS toggles exactly every SLOT_CYCLES cycles while busy. Frame period = 2·SLOT_CYCLES.
- Latency from `tx_en` (with FIFO non-empty) to WS rising: 1 cycle.
- Latency from WS edge to the MSB on SD: 1 cycle. This is the I2S one-bit delay.
- The receiver sees the WS edge one edge late and shifts 16 bits, so SLOT_CYCLES ≥ 17 is required for correct capture.
- `fifo_rden`:
  - at most one pulse per slot;
  - never asserted while `fifo_empty` = 1;
  - never asserted in reset.
- Bench check: `tx_finish` rises the cycle after the last right slot's final cycle, with WS = 0.

## Structure
- Shared package `iis_pkg`:
  - state encoding IDLE / LEFT / RIGHT (2 bits);
  - `IIS_SAMPLE_W` = 16;
  - `IIS_MIN_SLOT` = 17.
- The IIS receiver must use the same package constants.
- One sub-module: `iis_tx_shift`, a 16-bit parallel-load, MSB-first shift register with load/shift enables and a serial output register.
- Slot counter, state machine and run bookkeeping stay in `iis_transmit`.

## Test plan
- Basic frame:
  - Stimulus: FIFO holds 16'hA5C3, 16'h0F0F; SLOT_CYCLES = 32; pulse `tx_en`.
  - Response: WS high for 32 cycles, then low for 32 cycles. SD reproduces 1010010111000011, then 0000111100001111, each starting 1 cycle after its WS edge. Exactly 2 `fifo_rden` pulses.
- Loopback:
  - Stimulus: connect to the IIS receiver with `data_depth` = 8 and 8 random words.
  - Response: receiver L/R words match in order. `tx_finish` pulses once, and `tx_num` returns to 0.
- Underrun:
  - Stimulus: FIFO holds 1 word, `tx_en` held high.
  - Response: the left slot carries the word. The right slot carries 16'h0000. `tx_underrun` = 1 from the right slot's prefetch-cycle edge. No `fifo_rden` while empty.
- `tx_en` drop:
  - Stimulus: deassert `tx_en` at LEFT `c` = 5.
  - Response: left and right slots complete fully, then IDLE. WS = 0, `tx_underrun` clears, no further pops.
- Reset mid-slot:
  - Stimulus: assert `rst` at RIGHT `c` = 9.
  - Response: WS, SD, `fifo_rden`, `tx_num` and `tx_busy` are 0 immediately. After release with FIFO data, a new run starts with WS rising 1 cycle after `tx_en`.
- Minimum slot:
  - Stimulus: SLOT_CYCLES = 17, 4-sample run in loopback.
  - Response: all 4 words captured intact by the receiver. WS period = 34 cycles.

Source files
------------

// File: rtl/iis_pkg.sv
// ----------------------------------------------------------------------------
// iis_pkg
// Constants and types shared by the IIS transmit and receive paths.
//   iis_state_e  : slot sequencer state (IDLE / LEFT / RIGHT), 2-bit encoding
//   IIS_SAMPLE_W : audio sample width in bits
//   IIS_MIN_SLOT : shortest usable slot in bit clocks. The receiver sees the
//                  WS edge one clock late and then shifts a whole sample, so
//                  a slot must be at least one clock longer than a sample.
// ----------------------------------------------------------------------------
package iis_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } iis_state_e;

  localparam int IIS_SAMPLE_W = 16;
  localparam int IIS_MIN_SLOT = IIS_SAMPLE_W + 1;

  // Width of a counter that must reach slot_cycles-1.
  function automatic int slot_cnt_w(input int slot_cycles);
    return (slot_cycles > 1) ? $clog2(slot_cycles) : 1;
  endfunction

endpackage

// File: rtl/iis_tx_shift.sv
// ----------------------------------------------------------------------------
// iis_tx_shift
// MSB-first parallel-load shift register with a registered serial output.
//   clk, rst : bit clock, asynchronous active-high reset
//   clear    : force the register and the serial output to zero
//   load     : sd <= word MSB, the remaining bits wait in the register
//   shift    : sd <= next bit; zeros are shifted in behind the sample
//   word     : parallel sample to transmit
//   sd       : serial data output (registered)
// Priority is clear > load > shift. Because zeros follow the sample, sd
// naturally returns to 0 once all sample bits have been sent.
// ----------------------------------------------------------------------------
module iis_tx_shift
  import iis_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    load,
  input  logic                    shift,
  input  logic [IIS_SAMPLE_W-1:0] word,
  output logic                    sd
);

  logic [IIS_SAMPLE_W-1:0] sreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
      sd   <= 1'b0;
    end else if (clear) begin
      sreg <= '0;
      sd   <= 1'b0;
    end else if (load) begin
      sd   <= word[IIS_SAMPLE_W-1];
      sreg <= {word[IIS_SAMPLE_W-2:0], 1'b0};
    end else if (shift) begin
      sd   <= sreg[IIS_SAMPLE_W-1];
      sreg <= {sreg[IIS_SAMPLE_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/iis_transmit.sv
// ----------------------------------------------------------------------------
// iis_transmit
// I2S-style serial audio transmitter. Pops samples from a read FIFO and sends
// them in alternating left/right slots, MSB first, with the I2S one-bit delay
// between the WS edge and the MSB.
// Parameters:
//   data_depth  : samples per run (even, so a run always ends on a right slot)
//   SLOT_CYCLES : clk cycles per channel slot (at least IIS_MIN_SLOT)
// Ports:
//   clk, rst     : bit clock, asynchronous active-high reset
//   tx_en        : run enable, sampled in IDLE and at frame boundaries
//   fifo_empty   : source FIFO has no data
//   fifo_rdata   : FIFO read data, valid the cycle after fifo_rden
//   fifo_rden    : combinational pop request, at most one per slot
//   WS           : word select (1 = left, 0 = right), registered
//   SD           : serial data, registered
//   tx_busy      : a left or right slot is in progress
//   tx_num       : slots sent in the current run
//   tx_finish    : one-cycle pulse when a run completes data_depth samples
//   tx_underrun  : sticky, a slot found the FIFO empty; cleared by tx_en = 0
// ----------------------------------------------------------------------------
module iis_transmit
  import iis_pkg::*;
#(
  parameter int data_depth  = 1024,
  parameter int SLOT_CYCLES = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tx_en,
  input  logic                    fifo_empty,
  input  logic [IIS_SAMPLE_W-1:0] fifo_rdata,
  output logic                    fifo_rden,
  output logic                    WS,
  output logic                    SD,
  output logic                    tx_busy,
  output logic [31:0]             tx_num,
  output logic                    tx_finish,
  output logic                    tx_underrun
);

  localparam int              CW    = slot_cnt_w(SLOT_CYCLES);
  localparam logic [CW-1:0]   LAST  = CW'(SLOT_CYCLES - 1);
  localparam logic [31:0]     DEPTH = 32'(data_depth);

  iis_state_e state;
  logic [CW-1:0] c;
  // Remembers whether the word arriving at c = 0 was really popped; an
  // empty FIFO at the prefetch cycle turns the next slot into silence.
  logic prefetched;

  logic last_cycle;
  logic run_done;
  logic next_frame;
  logic pop;
  logic slot_active;
  logic [IIS_SAMPLE_W-1:0] slot_word;

  assign last_cycle  = (c == LAST);
  assign run_done    = (tx_num == DEPTH);
  assign next_frame  = tx_en && !run_done;
  assign slot_active = (state != IDLE);
  assign tx_busy     = slot_active;
  assign slot_word   = prefetched ? fifo_rdata : '0;

  // Pop request: the IDLE start pop, the left-slot prefetch, and the
  // right-slot prefetch only when another frame will follow.
  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE:    pop = tx_en && !fifo_empty;
      LEFT:    pop = last_cycle && !fifo_empty;
      RIGHT:   pop = last_cycle && next_frame && !fifo_empty;
      default: pop = 1'b0;
    endcase
  end

  // Gated with rst so no pop can leak out while the block is held in reset.
  assign fifo_rden = pop && !rst;

  // Slot sequencer, slot counter and run bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      c           <= '0;
      WS          <= 1'b0;
      prefetched  <= 1'b0;
      tx_num      <= '0;
      tx_finish   <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      tx_finish <= 1'b0;
      case (state)
        IDLE: begin
          c  <= '0;
          WS <= 1'b0;
          if (!tx_en) begin
            tx_num <= '0;
          end
          if (tx_en && !fifo_empty) begin
            state      <= LEFT;
            WS         <= 1'b1;
            prefetched <= 1'b1;
          end
        end

        LEFT: begin
          if (c == '0) begin
            tx_num <= tx_num + 32'd1;
          end
          if (last_cycle) begin
            state      <= RIGHT;
            WS         <= 1'b0;
            c          <= '0;
            prefetched <= !fifo_empty;
            if (fifo_empty) begin
              tx_underrun <= 1'b1;
            end
          end else begin
            c <= c + 1'b1;
          end
        end

        RIGHT: begin
          if (c == '0) begin
            tx_num <= tx_num + 32'd1;
          end
          if (last_cycle) begin
            c <= '0;
            if (next_frame) begin
              state      <= LEFT;
              WS         <= 1'b1;
              prefetched <= !fifo_empty;
              if (fifo_empty) begin
                tx_underrun <= 1'b1;
              end
            end else begin
              // A run only stops after a complete right slot, so no partial
              // frame is ever emitted.
              state      <= IDLE;
              WS         <= 1'b0;
              prefetched <= 1'b0;
              if (run_done) begin
                tx_finish <= 1'b1;
                tx_num    <= '0;
              end
            end
          end else begin
            c <= c + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          c     <= '0;
          WS    <= 1'b0;
        end
      endcase

      // Dropping tx_en acknowledges an underrun; this overrides a new set.
      if (!tx_en) begin
        tx_underrun <= 1'b0;
      end
    end
  end

  // The edge ending c = 0 loads the sample, so its MSB appears on SD one
  // cycle after the WS edge; later cycles shift the rest out.
  iis_tx_shift u_shift (
    .clk   (clk),
    .rst   (rst),
    .clear (!slot_active),
    .load  (slot_active && (c == '0)),
    .shift (slot_active && (c != '0)),
    .word  (slot_word),
    .sd    (SD)
  );

endmodule
